// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    MUL_LAST = 2'd2
  } state_e;

  localparam logic [3:0] ALUOP_MUL = 4'b1111;
  localparam logic [3:0] REG_ZERO  = 4'd0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register; MEM wins over WB.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [3:0] src_i,
  input  logic [3:0] mem_dst_i,
  input  logic       mem_regwrite_i,
  input  logic [3:0] wb_dst_i,
  input  logic       wb_regwrite_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_regwrite_i && (mem_dst_i != REG_ZERO) && (mem_dst_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_regwrite_i && (wb_dst_i != REG_ZERO) && (wb_dst_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, redirect flush,
// multi-cycle multiply stall FSM and saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_valid,
  input  logic [3:0]  ex_rs,
  input  logic [3:0]  ex_rt,
  input  logic [3:0]  ex_dst,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic [3:0]  ex_aluop,
  input  logic        ex_jump,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic [19:0] ex_jadr,
  input  logic [11:0] ex_badr,
  input  logic [3:0]  mem_dst,
  input  logic [3:0]  wb_dst,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  output logic        stall_if,
  output logic        stall_id,
  output logic        hold_ex,
  output logic        bubble_ex,
  output logic        bubble_mem,
  output logic        flush_if_id,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mul_busy
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  logic        redirect_hit, mul_hit, lu_hit;
  logic        mul_stall, do_lu, do_redir;
  logic [1:0]  fwd_a_raw, fwd_b_raw;

  // ex_regwrite and the upper jump-target bits carry no hazard information.
  logic        unused_ok;
  assign unused_ok = ^{ex_regwrite, ex_jadr[19:16]};

  assign redirect_hit = ex_valid && (ex_jump || (ex_branch && ex_zero));
  assign mul_hit      = ex_valid && (ex_aluop == ALUOP_MUL);
  assign lu_hit       = ex_valid && ex_memread && (ex_dst != REG_ZERO) &&
                        ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

  fwd_unit u_fwd_a (
    .src_i          (ex_rs),
    .mem_dst_i      (mem_dst),
    .mem_regwrite_i (mem_regwrite),
    .wb_dst_i       (wb_dst),
    .wb_regwrite_i  (wb_regwrite),
    .sel_o          (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .src_i          (ex_rt),
    .mem_dst_i      (mem_dst),
    .mem_regwrite_i (mem_regwrite),
    .wb_dst_i       (wb_dst),
    .wb_regwrite_i  (wb_regwrite),
    .sel_o          (fwd_b_raw)
  );

  // All decisions are gated by rst_n so combinational outputs read zero
  // for the whole duration of reset, not just after the next edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    do_lu     = 1'b0;
    do_redir  = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (redirect_hit) begin
            do_redir = 1'b1;
          end else if (mul_hit) begin
            mul_stall = 1'b1;
            if (MUL_LAT == 2) begin
              state_d = MUL_LAST;
            end else begin
              state_d = MUL_WAIT;
              cnt_d   = 4'(MUL_LAT - 2);
            end
          end else if (lu_hit) begin
            do_lu = 1'b1;
          end
        end
        MUL_WAIT: begin
          mul_stall = 1'b1;
          cnt_d     = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = MUL_LAST;
          end
        end
        MUL_LAST: begin
          if (redirect_hit) begin
            do_redir = 1'b1;
          end else if (lu_hit) begin
            do_lu = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_if) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (redirect_valid) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign stall_if       = mul_stall | do_lu;
  assign stall_id       = mul_stall | do_lu;
  assign hold_ex        = mul_stall;
  assign bubble_mem     = mul_stall;
  assign bubble_ex      = do_lu | do_redir;
  assign flush_if_id    = do_redir;
  assign redirect_valid = do_redir;
  assign redirect_pc    = !do_redir ? '0 :
                          ex_jump   ? ex_jadr[15:0] : {4'b0000, ex_badr};
  assign fwd_a          = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b          = rst_n ? fwd_b_raw : FWD_RF;
  assign mul_busy       = rst_n && (state_q == MUL_WAIT);
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run against a cycle-count based reference model.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_aluop, mem_dst, wb_dst;
  logic        id_uses_rt, ex_valid, ex_memread, ex_regwrite;
  logic        ex_jump, ex_branch, ex_zero, mem_regwrite, wb_regwrite;
  logic [19:0] ex_jadr;
  logic [11:0] ex_badr;
  logic        stall_if, stall_id, hold_ex, bubble_ex, bubble_mem;
  logic        flush_if_id, redirect_valid, mul_busy;
  logic [15:0] redirect_pc, stall_cnt, flush_cnt;
  logic [1:0]  fwd_a, fwd_b;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
    .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_jadr(ex_jadr), .ex_badr(ex_badr),
    .mem_dst(mem_dst), .wb_dst(wb_dst),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .stall_if(stall_if), .stall_id(stall_id), .hold_ex(hold_ex),
    .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .flush_if_id(flush_if_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_valid = 1'b0; ex_rs = '0; ex_rt = '0; ex_dst = '0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_aluop = '0;
    ex_jump = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0;
    ex_jadr = '0; ex_badr = '0;
    mem_dst = '0; wb_dst = '0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ctrl_vec();
    return {stall_if, stall_id, hold_ex, bubble_ex, bubble_mem,
            flush_if_id, redirect_valid, mul_busy, fwd_a, fwd_b};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    ex_valid = 1'b1; ex_jump = 1'b1; ex_jadr = 20'h01234;
    ex_memread = 1'b1; ex_dst = 4'd2; id_rs = 4'd2;
    ex_rs = 4'd2; ex_rt = 4'd2; mem_dst = 4'd2; mem_regwrite = 1'b1;
    #7;
    n_tests++;
    if (ctrl_vec() !== 12'h000) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected 000", ctrl_vec());
    end
    n_tests++;
    if (redirect_pc !== 16'h0000) begin
      n_fail++; $display("FAIL reset_pc: got %h expected 0000", redirect_pc);
    end
    n_tests++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %h expected 0", {stall_cnt, flush_cnt});
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if (ctrl_vec() !== 12'h000) begin
      n_fail++; $display("FAIL post_reset_idle: got %h expected 000", ctrl_vec());
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    tick();
    mem_dst = 4'd3; wb_dst = 4'd3; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    ex_rs = 4'd3; ex_rt = 4'd3;
    @(negedge clk);
    n_tests++;
    if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL fwd_a_mem: got %b expected 10", fwd_a); end
    n_tests++;
    if (fwd_b !== 2'b10) begin n_fail++; $display("FAIL fwd_b_mem: got %b expected 10", fwd_b); end
    mem_regwrite = 1'b0;
    #1;
    n_tests++;
    if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL fwd_a_wb: got %b expected 01", fwd_a); end
    ex_rs = 4'd0;
    #1;
    n_tests++;
    if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL fwd_a_rf: got %b expected 00", fwd_a); end
    n_tests++;
    if (fwd_b !== 2'b01) begin n_fail++; $display("FAIL fwd_b_wb: got %b expected 01", fwd_b); end
    wb_dst = 4'd0; mem_dst = 4'd0; mem_regwrite = 1'b1;
    #1;
    n_tests++;
    if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL fwd_r0: got %b expected 00", fwd_a); end
  endtask

  task automatic test_load_use();
    do_reset();
    tick();
    ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 4'd5; id_rs = 4'd5;
    @(negedge clk);
    n_tests++;
    if ({stall_if, stall_id, bubble_ex, hold_ex} !== 4'b1110) begin
      n_fail++; $display("FAIL load_use: got %b expected 1110", {stall_if, stall_id, bubble_ex, hold_ex});
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (stall_if !== 1'b0) begin n_fail++; $display("FAIL load_use_one_cycle: got %b expected 0", stall_if); end
    n_tests++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
    // rt match only counts when the instruction reads rt; r0 never hazards
    ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 4'd7; id_rt = 4'd7; id_rs = 4'd1;
    #1;
    n_tests++;
    if (stall_if !== 1'b0) begin n_fail++; $display("FAIL lu_rt_unused: got %b expected 0", stall_if); end
    id_uses_rt = 1'b1;
    #1;
    n_tests++;
    if (stall_if !== 1'b1) begin n_fail++; $display("FAIL lu_rt_used: got %b expected 1", stall_if); end
    ex_dst = 4'd0; id_rt = 4'd0;
    #1;
    n_tests++;
    if (stall_if !== 1'b0) begin n_fail++; $display("FAIL lu_r0: got %b expected 0", stall_if); end
  endtask

  task automatic test_multiply();
    do_reset();
    tick();
    ex_valid = 1'b1; ex_aluop = 4'b1111;
    @(negedge clk);
    n_tests++;
    if ({stall_if, stall_id, hold_ex, bubble_mem, mul_busy} !== 5'b11110) begin
      n_fail++; $display("FAIL mul_n: got %b expected 11110", {stall_if, stall_id, hold_ex, bubble_mem, mul_busy});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({stall_if, stall_id, hold_ex, bubble_mem, mul_busy} !== 5'b11111) begin
      n_fail++; $display("FAIL mul_n1: got %b expected 11111", {stall_if, stall_id, hold_ex, bubble_mem, mul_busy});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({stall_if, stall_id, hold_ex, bubble_mem, mul_busy} !== 5'b00000) begin
      n_fail++; $display("FAIL mul_n2: got %b expected 00000", {stall_if, stall_id, hold_ex, bubble_mem, mul_busy});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL mul_cnt: got %0d expected 2", stall_cnt); end
    // Back in IDLE: the still-present multiply opcode is detected afresh
    n_tests++;
    if ({stall_if, mul_busy} !== 2'b10) begin
      n_fail++; $display("FAIL mul_n3_idle: got %b expected 10", {stall_if, mul_busy});
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    tick();
    ex_valid = 1'b1; ex_jump = 1'b1; ex_jadr = 20'h0ABCD;
    ex_memread = 1'b1; ex_dst = 4'd5; id_rs = 4'd5; ex_aluop = 4'b1111;
    @(negedge clk);
    n_tests++;
    if (redirect_pc !== 16'hABCD) begin n_fail++; $display("FAIL jump_pc: got %h expected abcd", redirect_pc); end
    n_tests++;
    if ({redirect_valid, flush_if_id, bubble_ex, stall_if, hold_ex} !== 5'b11100) begin
      n_fail++; $display("FAIL jump_prio: got %b expected 11100", {redirect_valid, flush_if_id, bubble_ex, stall_if, hold_ex});
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if ({flush_cnt, stall_cnt, 15'd0, mul_busy} !== {16'd1, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL jump_after: got flush=%0d stall=%0d busy=%b expected 1 0 0", flush_cnt, stall_cnt, mul_busy);
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1; ex_badr = 12'h040;
    ex_jadr = 20'h0FFFF;
    @(negedge clk);
    n_tests++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 16'h0040}) begin
      n_fail++; $display("FAIL branch_taken: got %b/%h expected 1/0040", redirect_valid, redirect_pc);
    end
    tick();
    ex_zero = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({redirect_valid, flush_if_id, bubble_ex, redirect_pc} !== 19'd0) begin
      n_fail++; $display("FAIL branch_not_taken: got %b%b%b/%h expected 000/0000", redirect_valid, flush_if_id, bubble_ex, redirect_pc);
    end
    n_tests++;
    if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_cnt: got %0d expected 1", flush_cnt); end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    tick();
    ex_valid = 1'b1; ex_aluop = 4'b1111;
    tick();
    ex_rs = 4'd6; mem_dst = 4'd6; mem_regwrite = 1'b1;
    ex_jump = 1'b1; ex_jadr = 20'h01111;
    #1;
    n_tests++;
    if (mul_busy !== 1'b1) begin n_fail++; $display("FAIL mid_mul_busy: got %b expected 1", mul_busy); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ctrl_vec() !== 12'h000) begin
      n_fail++; $display("FAIL mid_mul_reset_ctrl: got %h expected 000", ctrl_vec());
    end
    n_tests++;
    if ({redirect_pc, stall_cnt, flush_cnt} !== 48'h0) begin
      n_fail++; $display("FAIL mid_mul_reset_regs: got %h expected 0", {redirect_pc, stall_cnt, flush_cnt});
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if (ctrl_vec() !== 12'h000) begin
      n_fail++; $display("FAIL mid_mul_post: got %h expected 000", ctrl_vec());
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [3:0] src, input logic [3:0] md,
                                         input logic mw, input logic [3:0] wd, input logic ww);
    if (mw && md != 0 && md == src) return 2'b10;
    if (ww && wd != 0 && wd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Model tracks how many cycles have elapsed since a multiply entered EX:
  // cycles 1..MUL_LAT-2 are blind stalls, cycle MUL_LAT-1 is the last one.
  task automatic test_random();
    int          mul_k = -1;
    int          e_sc = 0, e_fc = 0;
    logic        in_wait, in_last, redir, mstart, lu, stall;
    logic [15:0] e_pc;
    logic [11:0] e_ctrl;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_memread   = ($urandom_range(0, 3) == 0);
      ex_aluop     = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      ex_jump      = ($urandom_range(0, 7) == 0);
      ex_branch    = ($urandom_range(0, 3) == 0);
      ex_zero      = $urandom_range(0, 1) != 0;
      ex_jadr      = 20'($urandom);
      ex_badr      = 12'($urandom);
      id_rs        = 4'($urandom_range(0, 3));
      id_rt        = 4'($urandom_range(0, 3));
      id_uses_rt   = $urandom_range(0, 1) != 0;
      ex_rs        = 4'($urandom_range(0, 3));
      ex_rt        = 4'($urandom_range(0, 3));
      ex_dst       = 4'($urandom_range(0, 3));
      ex_regwrite  = $urandom_range(0, 1) != 0;
      mem_dst      = 4'($urandom_range(0, 3));
      wb_dst       = 4'($urandom_range(0, 3));
      mem_regwrite = $urandom_range(0, 1) != 0;
      wb_regwrite  = $urandom_range(0, 1) != 0;
      @(negedge clk);
      in_wait = (mul_k >= 1) && (mul_k <= MUL_LAT - 2);
      in_last = (mul_k == MUL_LAT - 1);
      redir   = !in_wait && ex_valid && (ex_jump || (ex_branch && ex_zero));
      mstart  = (mul_k < 0) && !redir && ex_valid && (ex_aluop == 4'hF);
      lu      = !in_wait && !redir && !mstart && ex_valid && ex_memread && (ex_dst != 0) &&
                ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
      stall   = in_wait || mstart || lu;
      e_pc    = !redir ? 16'h0 : ex_jump ? ex_jadr[15:0] : {4'h0, ex_badr};
      e_ctrl  = {stall, stall, in_wait || mstart, lu || redir, in_wait || mstart,
                 redir, redir, in_wait,
                 ref_fwd(ex_rs, mem_dst, mem_regwrite, wb_dst, wb_regwrite),
                 ref_fwd(ex_rt, mem_dst, mem_regwrite, wb_dst, wb_regwrite)};
      n_tests++;
      if (ctrl_vec() !== e_ctrl) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got %b expected %b (in_last=%b)", i, ctrl_vec(), e_ctrl, in_last);
      end
      n_tests++;
      if (redirect_pc !== e_pc) begin
        n_fail++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, redirect_pc, e_pc);
      end
      n_tests++;
      if ({stall_cnt, flush_cnt} !== {16'(e_sc), 16'(e_fc)}) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cnt, flush_cnt, e_sc, e_fc);
      end
      if (stall && e_sc < 65535) e_sc++;
      if (redir && e_fc < 65535) e_fc++;
      if (mstart) mul_k = 1;
      else if (mul_k >= 0) mul_k = (mul_k + 1 > MUL_LAT - 1) ? -1 : mul_k + 1;
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_multiply();
    test_redirect_priority();
    test_branch();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
